// File: rtl/csr_file_m.sv
// Machine-mode CSR file for the rv32 core: read-modify-write access with WARL
// masking, trap entry / mret state updates, 64-bit cycle and instret counters,
// interrupt-pending detection and trap-vector generation.
module csr_file_m #(
  parameter logic [31:0] HART_ID     = 32'd0,
  parameter logic [31:0] MVENDORID   = 32'd0,
  parameter logic [31:0] MARCHID     = 32'd0,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter bit          COUNTER_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        csr_en,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  input  logic        retire,
  input  logic        trap,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_tval,
  input  logic        mret,
  input  logic        irq_sw,
  input  logic        irq_timer,
  input  logic        irq_ext,
  output logic [31:0] trap_vector,
  output logic [31:0] mepc_o,
  output logic        irq_pending
);

  localparam logic [11:0] CsrMstatus   = 12'h300;
  localparam logic [11:0] CsrMisa      = 12'h301;
  localparam logic [11:0] CsrMie       = 12'h304;
  localparam logic [11:0] CsrMtvec     = 12'h305;
  localparam logic [11:0] CsrMscratch  = 12'h340;
  localparam logic [11:0] CsrMepc      = 12'h341;
  localparam logic [11:0] CsrMcause    = 12'h342;
  localparam logic [11:0] CsrMtval     = 12'h343;
  localparam logic [11:0] CsrMip       = 12'h344;
  localparam logic [11:0] CsrMcycle    = 12'hB00;
  localparam logic [11:0] CsrMinstret  = 12'hB02;
  localparam logic [11:0] CsrMcycleh   = 12'hB80;
  localparam logic [11:0] CsrMinstreth = 12'hB82;
  localparam logic [11:0] CsrMvendorid = 12'hF11;
  localparam logic [11:0] CsrMarchid   = 12'hF12;
  localparam logic [11:0] CsrMhartid   = 12'hF14;

  localparam logic [31:0] MisaVal  = 32'h4000_0100;
  localparam logic [31:0] MieMask  = 32'h0000_0888;
  localparam logic [31:0] MtvecRst = MTVEC_RESET & ~32'h2;

  // Architectural state; mstatus keeps only its two writable bits
  logic        mstat_mie_q, mstat_mie_d;
  logic        mstat_mpie_q, mstat_mpie_d;
  logic [31:0] mie_q, mie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;
  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;

  logic [31:0] mstatus_val;
  logic [31:0] mip_val;
  logic        addr_valid;
  logic        wr_en;
  logic [31:0] new_val;

  assign mstatus_val = {19'd0, 2'b11, 3'd0, mstat_mpie_q, 3'd0, mstat_mie_q, 3'd0};
  assign mip_val     = {20'd0, irq_ext, 3'd0, irq_timer, 3'd0, irq_sw, 3'd0};

  // Read mux and address decode; counters vanish from the map when disabled
  always_comb begin
    csr_rdata  = 32'd0;
    addr_valid = 1'b1;
    case (csr_addr)
      CsrMstatus:   csr_rdata = mstatus_val;
      CsrMisa:      csr_rdata = MisaVal;
      CsrMie:       csr_rdata = mie_q;
      CsrMtvec:     csr_rdata = mtvec_q;
      CsrMscratch:  csr_rdata = mscratch_q;
      CsrMepc:      csr_rdata = mepc_q;
      CsrMcause:    csr_rdata = mcause_q;
      CsrMtval:     csr_rdata = mtval_q;
      CsrMip:       csr_rdata = mip_val;
      CsrMvendorid: csr_rdata = MVENDORID;
      CsrMarchid:   csr_rdata = MARCHID;
      CsrMhartid:   csr_rdata = HART_ID;
      CsrMcycle: begin
        if (COUNTER_EN) csr_rdata = mcycle_q[31:0];
        else            addr_valid = 1'b0;
      end
      CsrMcycleh: begin
        if (COUNTER_EN) csr_rdata = mcycle_q[63:32];
        else            addr_valid = 1'b0;
      end
      CsrMinstret: begin
        if (COUNTER_EN) csr_rdata = minstret_q[31:0];
        else            addr_valid = 1'b0;
      end
      CsrMinstreth: begin
        if (COUNTER_EN) csr_rdata = minstret_q[63:32];
        else            addr_valid = 1'b0;
      end
      default: addr_valid = 1'b0;
    endcase
  end

  assign csr_illegal = csr_en & (~addr_valid | ((csr_op != 2'b00) & (csr_addr[11:10] == 2'b11)));

  // Trap and mret pre-empt a CSR write issued in the same cycle
  assign wr_en = csr_en & ~csr_illegal & (csr_op != 2'b00) & ~trap & ~mret;

  // Read-modify-write operand, before WARL masking
  always_comb begin
    new_val = csr_rdata;
    case (csr_op)
      2'b01:   new_val = csr_wdata;
      2'b10:   new_val = csr_rdata | csr_wdata;
      2'b11:   new_val = csr_rdata & ~csr_wdata;
      default: new_val = csr_rdata;
    endcase
  end

  // Next-state: counters free-run, then trap > mret > CSR write
  always_comb begin
    mstat_mie_d  = mstat_mie_q;
    mstat_mpie_d = mstat_mpie_q;
    mie_d        = mie_q;
    mtvec_d      = mtvec_q;
    mscratch_d   = mscratch_q;
    mepc_d       = mepc_q;
    mcause_d     = mcause_q;
    mtval_d      = mtval_q;
    mcycle_d     = mcycle_q + 64'd1;
    minstret_d   = minstret_q + {63'd0, retire};

    if (trap) begin
      mepc_d       = trap_pc & ~32'h3;
      mcause_d     = trap_cause;
      mtval_d      = trap_tval;
      mstat_mpie_d = mstat_mie_q;
      mstat_mie_d  = 1'b0;
    end else if (mret) begin
      mstat_mie_d  = mstat_mpie_q;
      mstat_mpie_d = 1'b1;
    end else if (wr_en) begin
      case (csr_addr)
        CsrMstatus: begin
          mstat_mie_d  = new_val[3];
          mstat_mpie_d = new_val[7];
        end
        CsrMie:       mie_d      = new_val & MieMask;
        CsrMtvec:     mtvec_d    = new_val & ~32'h2;
        CsrMscratch:  mscratch_d = new_val;
        CsrMepc:      mepc_d     = new_val & ~32'h3;
        CsrMcause:    mcause_d   = new_val;
        CsrMtval:     mtval_d    = new_val;
        // A write to either half suppresses the increment of the whole counter
        CsrMcycle:    mcycle_d   = {mcycle_q[63:32], new_val};
        CsrMcycleh:   mcycle_d   = {new_val, mcycle_q[31:0]};
        CsrMinstret:  minstret_d = {minstret_q[63:32], new_val};
        CsrMinstreth: minstret_d = {new_val, minstret_q[31:0]};
        default: ;
      endcase
    end

    if (!COUNTER_EN) begin
      mcycle_d   = 64'd0;
      minstret_d = 64'd0;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstat_mie_q  <= 1'b0;
      mstat_mpie_q <= 1'b0;
      mie_q        <= 32'd0;
      mtvec_q      <= MtvecRst;
      mscratch_q   <= 32'd0;
      mepc_q       <= 32'd0;
      mcause_q     <= 32'd0;
      mtval_q      <= 32'd0;
      mcycle_q     <= 64'd0;
      minstret_q   <= 64'd0;
    end else begin
      mstat_mie_q  <= mstat_mie_d;
      mstat_mpie_q <= mstat_mpie_d;
      mie_q        <= mie_d;
      mtvec_q      <= mtvec_d;
      mscratch_q   <= mscratch_d;
      mepc_q       <= mepc_d;
      mcause_q     <= mcause_d;
      mtval_q      <= mtval_d;
      mcycle_q     <= mcycle_d;
      minstret_q   <= minstret_d;
    end
  end

  // Vectored mode only offsets asynchronous (interrupt) causes
  always_comb begin
    trap_vector = {mtvec_q[31:2], 2'b00};
    if (mtvec_q[1:0] == 2'b01 && trap_cause[31]) begin
      trap_vector = {mtvec_q[31:2], 2'b00} + {25'd0, trap_cause[4:0], 2'b00};
    end
  end

  assign mepc_o      = mepc_q;
  assign irq_pending = mstat_mie_q & |(mie_q & mip_val);

endmodule

// File: doc/csr_file_m.md
Name: csr_file_m

Overview:
- Parametrised machine-mode CSR file for the rv32 core. Successor to the minimal CSR block.
- Adds:
  - read-modify-write ops (write/set/clear);
  - WARL masking;
  - trap entry and mret state updates;
  - 64-bit mcycle/minstret counters;
  - interrupt-pending detection and trap-vector computation.
- Sits beside the decode/execute stage; the core's trap logic consumes its outputs.

Parameters:
- HART_ID, 0, value returned by mhartid (0xF14)
- MVENDORID, 0, value returned by mvendorid (0xF11)
- MARCHID, 0, value returned by marchid (0xF12)
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec
- COUNTER_EN, 1, 1 = implement mcycle/minstret(h); 0 = those addresses are illegal

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- csr_en  in  1  CSR instruction valid this cycle
- csr_op  in  2  00 read-only, 01 write, 10 set, 11 clear (decoder issues 00 when set/clear operand is x0)
- csr_addr  in  12  CSR address
- csr_wdata  in  32  operand (rs1 or zimm)
- csr_rdata  out  32  current (pre-write) value of addressed CSR, combinational
- csr_illegal  out  1  combinational: access illegal, no state change
- retire  in  1  one instruction retired this cycle
- trap  in  1  take trap this cycle
- trap_cause  in  32  mcause value for the trap
- trap_pc  in  32  PC to save in mepc
- trap_tval  in  32  mtval value
- mret  in  1  mret executing this cycle
- irq_sw, irq_timer, irq_ext  in  1 each  level interrupt lines
- trap_vector  out  32  PC to jump to on trap, combinational
- mepc_o  out  32  mepc, for mret target
- irq_pending  out  1  enabled interrupt pending and globally enabled

Behaviour:
- Clock and reset:
  - Single clock clk; reset rst_n is asynchronous, active-low.
  - All state updates on posedge clk.
- Implemented CSRs and reset values:
  - mstatus 0x300 = 0x0000_1800
  - misa 0x301 = 0x4000_0100 (RV32I, writes ignored)
  - mie 0x304 = 0
  - mtvec 0x305 = MTVEC_RESET
  - mscratch 0x340 = 0
  - mepc 0x341 = 0
  - mcause 0x342 = 0
  - mtval 0x343 = 0
  - mip 0x344
  - mcycle 0xB00 / mcycleh 0xB80 = 0
  - minstret 0xB02 / minstreth 0xB82 = 0
  - mvendorid/marchid/mhartid constants
- WARL masks:
  - mstatus: only MIE[3] and MPIE[7] writable; MPP[12:11] reads 2'b11; other bits read 0.
  - mie: bits 3, 7, 11 writable, others 0.
  - mtvec: bit1 forced 0 (modes 00 direct, 01 vectored).
  - mepc: bits[1:0] forced 0.
- mip: read-only, equals {irq_ext<<11 | irq_timer<<7 | irq_sw<<3}, unregistered. Writes to it are ignored, not illegal.
- New value per op:
  - write = wdata;
  - set = old | wdata;
  - clear = old & ~wdata.
  - The masked result is written at posedge when csr_en and !csr_illegal and op != 00.
- csr_illegal = csr_en & (unimplemented address | (op != 00 & addr[11:10] == 2'b11)).
- Counters:
  - mcycle increments every cycle.
  - minstret increments when retire is high.
  - Both are 64-bit, low half carries into high half; wrap from all-ones to 0.
  - A CSR write to any half that cycle wins over the increment for the whole 64-bit counter: the written half takes the new value, the other half holds.
- Priority in one cycle: trap > mret > CSR write. A lower-priority event in the same cycle is dropped; counters still increment.
- Trap entry (next edge):
  - mepc <= trap_pc & ~3
  - mcause <= trap_cause
  - mtval <= trap_tval
  - MPIE <= MIE
  - MIE <= 0
- mret: MIE <= MPIE, MPIE <= 1.
- trap_vector:
  - If mtvec mode 01 and trap_cause[31] = 1: {mtvec[31:2],2'b00} + 4*trap_cause[4:0].
  - Otherwise: {mtvec[31:2],2'b00}.
- irq_pending = mstatus.MIE & |(mie & mip), combinational.
- Reset mid-operation: all registers return to reset values immediately; an in-flight write is lost.

Test Plan:
- Reset, then read 0x300, 0x305, 0xF14 with HART_ID=3 -> 0x1800, MTVEC_RESET, 3; csr_illegal=0.
- Write mie=0xFFFF_FFFF, then set 0x300 with 0x8 -> mie reads 0x888, mstatus reads 0x1808. Then clear 0x300 with 0x8 -> 0x1800.
- MIE=1, mie=0x80, pulse irq_timer -> irq_pending=1 same cycle. Trap with cause 0x8000_0007, pc 0x104, mtvec=0x101 -> trap_vector=0x11C. Next cycle: mepc=0x104, mstatus=0x1880. mret -> mstatus=0x1888.
- Write 0xFFFF_FFFF to mcycle and 0 to mcycleh, then idle 2 cycles -> mcycleh=1, mcycle=0x0000_0000 then 1. A write to minstret with retire=1 in the same cycle -> written value, no increment.
- Write to 0xF11, read 0x7C0 -> csr_illegal=1, no state change. COUNTER_EN=0: access 0xB00 -> illegal.
- trap and a CSR write to mscratch in the same cycle -> trap state updated, mscratch unchanged. Assert rst_n low mid-sequence -> all CSRs at reset values asynchronously.
